// File: rtl/seg7_scan_decoder.sv
// Rebuilds the two 16-bit counter values from a multiplexed 8-digit seven-segment bus
// by waiting for each strobed digit to settle, decoding it and assembling full frames.
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES = 16,
    parameter int FRAME_TIMEOUT = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  hex_i,
    input  logic [7:0]  an_i,
    output logic [15:0] val_1_o,
    output logic [15:0] val_2_o,
    output logic        frame_valid_o,
    output logic [7:0]  digit_mask_o,
    output logic        seg_err_o,
    output logic        an_err_o,
    output logic        timeout_o,
    output logic [7:0]  err_cnt_o
);
    localparam int              TO_W      = $clog2(FRAME_TIMEOUT) + 1;
    localparam logic [7:0]      STAB_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(FRAME_TIMEOUT - 1);

    typedef enum logic {SETTLE, HELD} state_t;

    state_t          state;
    logic [7:0]      r_an;
    logic [7:0]      p_an;
    logic [6:0]      r_hex;
    logic [6:0]      p_hex;
    logic [7:0]      stab_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [31:0]     store;

    logic       same;
    logic       eval;
    logic       blank;
    logic       one_low;
    logic       dec_ok;
    logic [3:0] nib;
    logic [2:0] idx;
    logic       capture;
    logic       seg_err_d;
    logic       an_err_d;
    logic       frame_done;
    logic       frame_to;
    logic [7:0] mask_next;
    logic       unused_dp;

    assign unused_dp = hex_i[7];

    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h40:   decode = {1'b1, 4'h0};
            7'h79:   decode = {1'b1, 4'h1};
            7'h24:   decode = {1'b1, 4'h2};
            7'h30:   decode = {1'b1, 4'h3};
            7'h19:   decode = {1'b1, 4'h4};
            7'h12:   decode = {1'b1, 4'h5};
            7'h02:   decode = {1'b1, 4'h6};
            7'h78:   decode = {1'b1, 4'h7};
            7'h00:   decode = {1'b1, 4'h8};
            7'h10:   decode = {1'b1, 4'h9};
            7'h08:   decode = {1'b1, 4'hA};
            7'h03:   decode = {1'b1, 4'hB};
            7'h46:   decode = {1'b1, 4'hC};
            7'h21:   decode = {1'b1, 4'hD};
            7'h06:   decode = {1'b1, 4'hE};
            7'h0E:   decode = {1'b1, 4'hF};
            default: decode = 5'h00;
        endcase
    endfunction

    // Position of the lit digit; only meaningful when exactly one strobe is low.
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!r_an[i]) idx = 3'(i);
        end
    end

    assign same          = (r_an == p_an) && (r_hex == p_hex);
    assign eval          = (state == SETTLE) && same && (stab_cnt == STAB_LAST);
    assign blank         = (r_an == 8'hFF);
    assign one_low       = $onehot(~r_an);
    assign {dec_ok, nib} = decode(r_hex);
    assign capture       = eval && one_low && dec_ok;
    assign seg_err_d     = eval && one_low && !dec_ok;
    assign an_err_d      = eval && !blank && !one_low;
    assign frame_done    = (digit_mask_o == 8'hFF);
    assign frame_to      = !frame_done && (digit_mask_o != 8'h00) && (to_cnt == TO_LAST);

    // A capture landing on a timeout cycle starts the next partial frame.
    always_comb begin
        mask_next = (frame_done || frame_to) ? 8'h00 : digit_mask_o;
        if (capture) mask_next[idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SETTLE;
            r_an          <= 8'h00;
            p_an          <= 8'h00;
            r_hex         <= 7'h00;
            p_hex         <= 7'h00;
            stab_cnt      <= 8'h00;
            to_cnt        <= '0;
            store         <= 32'h0;
            val_1_o       <= 16'h0;
            val_2_o       <= 16'h0;
            frame_valid_o <= 1'b0;
            digit_mask_o  <= 8'h00;
            seg_err_o     <= 1'b0;
            an_err_o      <= 1'b0;
            timeout_o     <= 1'b0;
            err_cnt_o     <= 8'h00;
        end else begin
            r_an  <= an_i;
            r_hex <= hex_i[6:0];
            p_an  <= r_an;
            p_hex <= r_hex;

            // Evaluation happens once per stable sample; HELD waits for the next change.
            case (state)
                SETTLE: begin
                    if (!same) begin
                        stab_cnt <= 8'd1;
                    end else begin
                        stab_cnt <= stab_cnt + 8'd1;
                        if (eval) state <= HELD;
                    end
                end
                HELD: begin
                    if (!same) begin
                        stab_cnt <= 8'd1;
                        state    <= SETTLE;
                    end
                end
                default: state <= SETTLE;
            endcase

            seg_err_o <= seg_err_d;
            an_err_o  <= an_err_d;
            if ((seg_err_d || an_err_d) && (err_cnt_o != 8'hFF)) begin
                err_cnt_o <= err_cnt_o + 8'd1;
            end

            if (capture) store[idx*4 +: 4] <= nib;

            frame_valid_o <= 1'b0;
            timeout_o     <= 1'b0;
            if (frame_done) begin
                val_1_o       <= store[31:16];
                val_2_o       <= store[15:0];
                frame_valid_o <= 1'b1;
                to_cnt        <= '0;
            end else if (frame_to) begin
                timeout_o <= 1'b1;
                to_cnt    <= '0;
            end else if (digit_mask_o != 8'h00) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            digit_mask_o <= mask_next;
        end
    end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Drives digit strobes onto the display bus and compares the recovered frames, error
// pulses and counters with a table-driven model of the scan protocol.
module tb_seg7_scan_decoder;
    localparam int SC = 4;
    localparam int FT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  hex_i;
    logic [7:0]  an_i;
    logic [15:0] val_1_o;
    logic [15:0] val_2_o;
    logic        frame_valid_o;
    logic [7:0]  digit_mask_o;
    logic        seg_err_o;
    logic        an_err_o;
    logic        timeout_o;
    logic [7:0]  err_cnt_o;

    seg7_scan_decoder #(.STABLE_CYCLES(SC), .FRAME_TIMEOUT(FT)) dut (
        .clk(clk), .rst(rst), .hex_i(hex_i), .an_i(an_i),
        .val_1_o(val_1_o), .val_2_o(val_2_o), .frame_valid_o(frame_valid_o),
        .digit_mask_o(digit_mask_o), .seg_err_o(seg_err_o), .an_err_o(an_err_o),
        .timeout_o(timeout_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    int checks;
    int failures;

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [3:0]  m_store [8];
    logic [7:0]  m_mask;
    logic [15:0] m_v1;
    logic [15:0] m_v2;
    int          m_frames, m_seg, m_an, m_err;

    logic [7:0] last_an;
    logic [7:0] last_hex;

    // Pulse counters and timing marks observed away from the active edge.
    int         n_frames = 0, n_seg = 0, n_an = 0, n_to = 0;
    int         cyc = 0, rise_cyc = 0, to_cyc = 0;
    logic [7:0] prev_mask = 8'h00;
    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_mask <= digit_mask_o;
        if (!rst) begin
            if (frame_valid_o) n_frames <= n_frames + 1;
            if (seg_err_o)     n_seg    <= n_seg + 1;
            if (an_err_o)      n_an     <= n_an + 1;
            if (timeout_o) begin
                n_to   <= n_to + 1;
                to_cyc <= cyc;
            end
            if (prev_mask == 8'h00 && digit_mask_o != 8'h00) rise_cyc <= cyc;
        end
    end

    function automatic logic [7:0] an_of(input int k);
        return ~(8'h01 << k);
    endfunction

    function automatic logic [7:0] seg_of(input logic [3:0] n, input logic dp);
        return {dp, seg_tbl[n]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_store[i] = 4'h0;
        m_mask = 8'h00; m_v1 = 16'h0; m_v2 = 16'h0;
        m_frames = 0; m_seg = 0; m_an = 0; m_err = 0;
    endtask

    // A stable sample: blank does nothing, one lit digit decodes, anything else is an error.
    task automatic model_apply(input logic [7:0] an, input logic [7:0] hex);
        int zeros, k, v;
        zeros = 0; k = 0; v = -1;
        for (int i = 0; i < 8; i++) if (!an[i]) begin zeros++; k = i; end
        if (zeros == 0) return;
        if (zeros > 1) begin
            m_an++;
            if (m_err < 255) m_err++;
            return;
        end
        for (int d = 0; d < 16; d++) if (seg_tbl[d] == hex[6:0]) v = d;
        if (v < 0) begin
            m_seg++;
            if (m_err < 255) m_err++;
            return;
        end
        m_store[k] = 4'(v);
        m_mask[k]  = 1'b1;
        if (m_mask == 8'hFF) begin
            m_v1 = {m_store[7], m_store[6], m_store[5], m_store[4]};
            m_v2 = {m_store[3], m_store[2], m_store[1], m_store[0]};
            m_frames++;
            m_mask = 8'h00;
        end
    endtask

    task automatic present(input logic [7:0] an, input logic [7:0] hex, input int hold);
        if (an != 8'hFF && an == last_an && hex[6:0] == last_hex[6:0]) begin
            an_i = 8'hFF; hex_i = 8'hFF; last_an = 8'hFF; last_hex = 8'hFF;
            @(negedge clk);
        end
        an_i = an; hex_i = hex; last_an = an; last_hex = hex;
        repeat (hold) @(negedge clk);
        if (hold >= SC) model_apply(an, hex);
    endtask

    task automatic scan_all(input logic [31:0] digs, input int hold);
        for (int k = 7; k >= 0; k--) present(an_of(k), seg_of(digs[4*k +: 4], 1'b1), hold);
    endtask

    task automatic test_reset();
        rst = 1'b1; an_i = 8'hFF; hex_i = 8'hFF; last_an = 8'hFF; last_hex = 8'hFF;
        repeat (3) @(negedge clk);
        checks++;
        if ({val_1_o, val_2_o} !== 32'h0) begin
            failures++; $display("[TB] FAIL reset_vals: got %h expected 0", {val_1_o, val_2_o});
        end
        checks++;
        if (digit_mask_o !== 8'h00) begin
            failures++; $display("[TB] FAIL reset_mask: got %h expected 00", digit_mask_o);
        end
        checks++;
        if (err_cnt_o !== 8'h00) begin
            failures++; $display("[TB] FAIL reset_errcnt: got %h expected 00", err_cnt_o);
        end
        checks++;
        if ({frame_valid_o, seg_err_o, an_err_o, timeout_o} !== 4'b0) begin
            failures++;
            $display("[TB] FAIL reset_pulses: got %b expected 0000",
                     {frame_valid_o, seg_err_o, an_err_o, timeout_o});
        end
        rst = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic test_basic_scan();
        int b_fr;
        b_fr = n_frames;
        scan_all(32'h1234ABCD, 7);
        present(8'hFF, 8'hFF, 8);
        checks++;
        if (n_frames - b_fr !== 1) begin
            failures++; $display("[TB] FAIL basic_frames: got %0d expected 1", n_frames - b_fr);
        end
        checks++;
        if (val_1_o !== 16'h1234) begin
            failures++; $display("[TB] FAIL basic_val1: got %h expected 1234", val_1_o);
        end
        checks++;
        if (val_2_o !== 16'hABCD) begin
            failures++; $display("[TB] FAIL basic_val2: got %h expected abcd", val_2_o);
        end
        checks++;
        if (err_cnt_o !== 8'h00) begin
            failures++; $display("[TB] FAIL basic_errcnt: got %h expected 00", err_cnt_o);
        end
    endtask

    task automatic test_glitch();
        int b_fr;
        logic [31:0] digs;
        b_fr = n_frames;
        present(an_of(3), 8'h99, SC - 1);
        present(8'hFF, 8'hFF, 6);
        checks++;
        if (digit_mask_o !== 8'h00) begin
            failures++; $display("[TB] FAIL glitch_mask: got %h expected 00", digit_mask_o);
        end
        digs = $urandom();
        scan_all(digs, 7);
        present(8'hFF, 8'hFF, 8);
        checks++;
        if ({val_1_o, val_2_o} !== {m_v1, m_v2}) begin
            failures++; $display("[TB] FAIL glitch_vals: got %h expected %h", {val_1_o, val_2_o}, {m_v1, m_v2});
        end
        checks++;
        if (n_frames - b_fr !== 1) begin
            failures++; $display("[TB] FAIL glitch_frames: got %0d expected 1", n_frames - b_fr);
        end
    endtask

    task automatic test_errors();
        int b_seg, b_an;
        b_seg = n_seg; b_an = n_an;
        present(an_of(5), 8'hFF, 10);
        checks++;
        if (n_seg - b_seg !== 1) begin
            failures++; $display("[TB] FAIL seg_err_pulses: got %0d expected 1", n_seg - b_seg);
        end
        checks++;
        if (err_cnt_o !== 8'd1) begin
            failures++; $display("[TB] FAIL seg_err_cnt: got %0d expected 1", err_cnt_o);
        end
        checks++;
        if (digit_mask_o !== m_mask) begin
            failures++; $display("[TB] FAIL seg_err_mask: got %h expected %h", digit_mask_o, m_mask);
        end
        present(8'b1111_0011, seg_of(4'h3, 1'b1), 10);
        checks++;
        if (n_an - b_an !== 1) begin
            failures++; $display("[TB] FAIL an_err_pulses: got %0d expected 1", n_an - b_an);
        end
        checks++;
        if (err_cnt_o !== 8'd2) begin
            failures++; $display("[TB] FAIL an_err_cnt: got %0d expected 2", err_cnt_o);
        end
        present(8'hFF, 8'hFF, 6);
    endtask

    task automatic test_timeout();
        int b_fr, b_to;
        b_fr = n_frames; b_to = n_to;
        for (int k = 0; k < 7; k++) present(an_of(k), seg_of(4'($urandom_range(0, 15)), 1'b1), 7);
        present(8'hFF, 8'hFF, 40);
        m_mask = 8'h00;
        checks++;
        if (n_to - b_to !== 1) begin
            failures++; $display("[TB] FAIL timeout_pulses: got %0d expected 1", n_to - b_to);
        end
        checks++;
        if (to_cyc - rise_cyc !== FT) begin
            failures++; $display("[TB] FAIL timeout_delay: got %0d expected %0d", to_cyc - rise_cyc, FT);
        end
        checks++;
        if (digit_mask_o !== 8'h00) begin
            failures++; $display("[TB] FAIL timeout_mask: got %h expected 00", digit_mask_o);
        end
        checks++;
        if ({val_1_o, val_2_o} !== {m_v1, m_v2}) begin
            failures++; $display("[TB] FAIL timeout_vals: got %h expected %h", {val_1_o, val_2_o}, {m_v1, m_v2});
        end
        checks++;
        if (n_frames - b_fr !== 0) begin
            failures++; $display("[TB] FAIL timeout_frames: got %0d expected 0", n_frames - b_fr);
        end
    endtask

    task automatic test_overwrite();
        int b_fr;
        b_fr = n_frames;
        present(an_of(0), 8'h82, 7);
        for (int k = 1; k < 7; k++) present(an_of(k), seg_of(4'($urandom_range(0, 15)), 1'b1), 7);
        present(an_of(0), 8'hF8, 7);
        present(an_of(7), seg_of(4'($urandom_range(0, 15)), 1'b1), 7);
        present(8'hFF, 8'hFF, 8);
        checks++;
        if (val_2_o[3:0] !== 4'h7) begin
            failures++; $display("[TB] FAIL overwrite_digit0: got %h expected 7", val_2_o[3:0]);
        end
        checks++;
        if ({val_1_o, val_2_o} !== {m_v1, m_v2}) begin
            failures++; $display("[TB] FAIL overwrite_vals: got %h expected %h", {val_1_o, val_2_o}, {m_v1, m_v2});
        end
        checks++;
        if (n_frames - b_fr !== 1) begin
            failures++; $display("[TB] FAIL overwrite_frames: got %0d expected 1", n_frames - b_fr);
        end
    endtask

    task automatic test_random_scans();
        int ord [8];
        int b_fr, b_seg, b_an, mf, ms, ma, j, t;
        logic [7:0] jan;
        for (int it = 0; it < 6; it++) begin
            b_fr = n_frames; b_seg = n_seg; b_an = n_an;
            mf = m_frames; ms = m_seg; ma = m_an;
            jan = (it % 2 == 0) ? 8'($urandom()) : an_of($urandom_range(0, 7));
            present(jan, 8'($urandom()), 7);
            checks++;
            if (digit_mask_o !== m_mask) begin
                failures++; $display("[TB] FAIL rand_junk_mask: got %h expected %h", digit_mask_o, m_mask);
            end
            for (int i = 0; i < 8; i++) ord[i] = i;
            for (int i = 7; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
            for (int i = 0; i < 8; i++) begin
                present(an_of(ord[i]), seg_of(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1))),
                        $urandom_range(6, 7));
                checks++;
                if (digit_mask_o !== m_mask) begin
                    failures++; $display("[TB] FAIL rand_mask: got %h expected %h", digit_mask_o, m_mask);
                end
            end
            present(8'hFF, 8'hFF, 8);
            checks++;
            if ({val_1_o, val_2_o} !== {m_v1, m_v2}) begin
                failures++; $display("[TB] FAIL rand_vals: got %h expected %h", {val_1_o, val_2_o}, {m_v1, m_v2});
            end
            checks++;
            if (n_frames - b_fr !== m_frames - mf) begin
                failures++; $display("[TB] FAIL rand_frames: got %0d expected %0d", n_frames - b_fr, m_frames - mf);
            end
            checks++;
            if ({n_seg - b_seg, n_an - b_an} !== {m_seg - ms, m_an - ma}) begin
                failures++;
                $display("[TB] FAIL rand_err_pulses: got seg=%0d an=%0d expected seg=%0d an=%0d",
                         n_seg - b_seg, n_an - b_an, m_seg - ms, m_an - ma);
            end
            checks++;
            if (err_cnt_o !== 8'(m_err)) begin
                failures++; $display("[TB] FAIL rand_errcnt: got %0d expected %0d", err_cnt_o, m_err);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int b_fr;
        for (int k = 0; k < 6; k++) present(an_of(k), seg_of(4'($urandom_range(0, 15)), 1'b1), 7);
        checks++;
        if (digit_mask_o !== 8'h3F) begin
            failures++; $display("[TB] FAIL midrst_premask: got %h expected 3f", digit_mask_o);
        end
        an_i = an_of(6); hex_i = seg_of(4'h5, 1'b1); rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({val_1_o, val_2_o, digit_mask_o, err_cnt_o} !== 48'h0) begin
            failures++;
            $display("[TB] FAIL midrst_outputs: got %h expected 0", {val_1_o, val_2_o, digit_mask_o, err_cnt_o});
        end
        checks++;
        if ({frame_valid_o, seg_err_o, an_err_o, timeout_o} !== 4'b0) begin
            failures++;
            $display("[TB] FAIL midrst_pulses: got %b expected 0000",
                     {frame_valid_o, seg_err_o, an_err_o, timeout_o});
        end
        rst = 1'b0;
        model_clear();
        last_an = an_i; last_hex = hex_i;
        repeat (SC - 1) @(negedge clk);
        b_fr = n_frames;
        present(8'hFF, 8'hFF, 8);
        checks++;
        if (digit_mask_o !== 8'h00) begin
            failures++; $display("[TB] FAIL midrst_fresh_settle: got %h expected 00", digit_mask_o);
        end
        scan_all($urandom(), 7);
        present(8'hFF, 8'hFF, 8);
        checks++;
        if ({val_1_o, val_2_o} !== {m_v1, m_v2}) begin
            failures++; $display("[TB] FAIL midrst_vals: got %h expected %h", {val_1_o, val_2_o}, {m_v1, m_v2});
        end
        checks++;
        if (n_frames - b_fr !== 1) begin
            failures++; $display("[TB] FAIL midrst_frames: got %0d expected 1", n_frames - b_fr);
        end
    endtask

    task automatic test_err_saturation();
        int b_an;
        b_an = n_an;
        for (int i = 0; i < 255; i++) present((i % 2 == 0) ? 8'h00 : 8'hF3, 8'hFF, SC + 1);
        checks++;
        if (err_cnt_o !== 8'(m_err)) begin
            failures++; $display("[TB] FAIL sat_errcnt_255: got %0d expected %0d", err_cnt_o, m_err);
        end
        present(8'hF3, 8'hFF, SC + 1);
        present(8'hFF, 8'hFF, 4);
        checks++;
        if (err_cnt_o !== 8'hFF) begin
            failures++; $display("[TB] FAIL sat_errcnt_hold: got %0d expected 255", err_cnt_o);
        end
        checks++;
        if (n_an - b_an !== 256) begin
            failures++; $display("[TB] FAIL sat_an_pulses: got %0d expected 256", n_an - b_an);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic_scan();
        test_glitch();
        test_errors();
        test_timeout();
        test_overwrite();
        test_random_scans();
        test_reset_mid_frame();
        test_err_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: run exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
